// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: emulates an OV7670 DVP sensor (PCLK/VSYNC/HREF/D) in RGB565 VGA timing with test patterns.
// Latency: enable sampled 1 on a PCLK falling edge raises vsync on that same clk25 edge; all outputs registered.
// Backpressure: none -- free-running source; enable only gates the start of the next frame.
//
// Ports: clk25/rst (async active-high); enable, mode[1:0], const_pixel[15:0] control inputs;
//        pclk, vsync, href, d[7:0] sensor-side outputs; frame_done one-clk25 end-of-frame pulse.
// Build option: define OV7670_GEN_FRAME_CNT_EN to stamp a 16-bit frame counter into pixel (0,0).
module ov7670_stream_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 144,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 17,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10
) (
   input  logic        clk25,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [15:0] const_pixel,
   output logic        pclk,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        frame_done
);

   localparam int LINE    = 2 * (H_ACTIVE + H_BLANK);
   localparam int COL_W   = $clog2(LINE);
   localparam int MAX_A   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
   localparam int MAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int ROW_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int ROW_W   = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BACK, S_ACTIVE, S_FRONT} state_t;

   state_t             state_q, state_d;
   logic               phase_q;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [BAR_CW-1:0]  bar_px_q, bar_px_d;
   logic [2:0]         bar_idx_q, bar_idx_d;
   logic [1:0]         mode_q, mode_d;
   logic [15:0]        cpix_q, cpix_d;
   logic               vsync_q, href_q, done_q;
   logic [7:0]         d_q;
   logic               vsync_d, href_d, done_d;
   logic [7:0]         d_d;
   logic [15:0]        x_pix, y_pix, pix;
   logic               line_end, frame_start;
   int                 last_row;
`ifdef OV7670_GEN_FRAME_CNT_EN
   logic [15:0]        frame_cnt_q, frame_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      bar_px_d    = bar_px_q;
      bar_idx_d   = bar_idx_q;
      mode_d      = mode_q;
      cpix_d      = cpix_q;
      done_d      = 1'b0;
      frame_start = 1'b0;
      line_end    = (int'(col_q) == LINE - 1);

      case (state_q)
         S_SYNC:   last_row = V_SYNC - 1;
         S_BACK:   last_row = V_BACK - 1;
         S_ACTIVE: last_row = V_ACTIVE - 1;
         S_FRONT:  last_row = V_FRONT - 1;
         default:  last_row = 0;
      endcase

      if (state_q == S_IDLE) begin
         col_d = '0;
         row_d = '0;
         if (enable) begin
            state_d     = S_SYNC;
            frame_start = 1'b1;
         end
      end else begin
         col_d = line_end ? '0 : col_q + 1'b1;
         if (line_end) begin
            if (int'(row_q) == last_row) begin
               row_d = '0;
               case (state_q)
                  S_SYNC:   state_d = S_BACK;
                  S_BACK:   state_d = S_ACTIVE;
                  S_ACTIVE: state_d = S_FRONT;
                  default: begin
                     // End of FRONT: the next SYNC follows with no gap when still enabled.
                     done_d = 1'b1;
                     if (enable) begin
                        state_d     = S_SYNC;
                        frame_start = 1'b1;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end
               endcase
            end else begin
               row_d = row_q + 1'b1;
            end
         end
      end

      if (frame_start) begin
         mode_d = mode;
         cpix_d = const_pixel;
      end

      // Bar tracking without a divider: count pixels within a bar, bump the bar index on wrap.
      if (col_d == '0) begin
         bar_px_d  = '0;
         bar_idx_d = '0;
      end else if (!col_d[0]) begin
         if (int'(bar_px_q) == BAR_W - 1) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 1'b1;
         end else begin
            bar_px_d = bar_px_q + 1'b1;
         end
      end

      x_pix = 16'(col_d >> 1);
      y_pix = 16'(row_d);

      case (mode_d)
         2'd0: begin
            case (bar_idx_d)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd1:    pix = x_pix + y_pix;
         2'd2:    pix = (x_pix[3] ^ y_pix[3]) ? 16'hFFFF : 16'h0000;
         default: pix = cpix_d;
      endcase

`ifdef OV7670_GEN_FRAME_CNT_EN
      frame_cnt_d = frame_cnt_q + 16'(done_d);
      if (row_d == '0 && x_pix == 16'd0) begin
         pix = frame_cnt_q;
      end
`endif

      vsync_d = (state_d == S_SYNC);
      href_d  = (state_d == S_ACTIVE) && (int'(col_d) < 2 * H_ACTIVE);
      d_d     = href_d ? (col_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         phase_q   <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         bar_px_q  <= '0;
         bar_idx_q <= '0;
         mode_q    <= '0;
         cpix_q    <= '0;
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         d_q       <= '0;
         done_q    <= 1'b0;
`ifdef OV7670_GEN_FRAME_CNT_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         phase_q <= ~phase_q;
         done_q  <= 1'b0;
         // Everything except phase advances only on the PCLK falling edge.
         if (phase_q) begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            cpix_q    <= cpix_d;
            vsync_q   <= vsync_d;
            href_q    <= href_d;
            d_q       <= d_d;
            done_q    <= done_d;
`ifdef OV7670_GEN_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
         end
      end
   end

   assign pclk       = phase_q;
   assign vsync      = vsync_q;
   assign href       = href_q;
   assign d          = d_q;
   assign frame_done = done_q;

endmodule
